pc_sequencer: RTL and testbench

- Parametrised fetch-PC sequencer and the successor of the combinational next-PC logic.
- Holds the word-addressed program counter and resolves branch, jump and jump-register redirects from the execute stage.
- Six branch conditions replace the beq/bne pair.
- Adds stall, halt/resume, a one-cycle flush pulse and a saturating taken-redirect counter; sits between the execute stage and instruction fetch.

---
 rtl/pc_sequencer.sv | 126 ++++++++++++
 tb/tb_pc_sequencer.sv | 259 +++++++++++++++++++++++++
 2 files changed

// File: rtl/pc_sequencer.sv
// pc_sequencer: fetch-PC sequencer with branch/jump/JR redirects, stall, halt/resume and taken counter.
// Optional return-address stack enabled by defining PC_SEQ_RAS_EN.
module pc_sequencer #(
  parameter int AW = 30,
  parameter logic [AW-1:0] RESET_ADDR = '0,
  parameter int CW = 16,
  parameter int RAS_DEPTH = 4
) (
  input  logic          i_clk,
  input  logic          i_rst_n,
  input  logic          i_stall,
  input  logic          i_halt,
  input  logic          i_resume,
  input  logic          i_br_valid,
  input  logic [2:0]    i_cond,
  input  logic          i_zero,
  input  logic          i_neg,
  input  logic          i_jump,
  input  logic          i_jr,
  input  logic          i_call,
  input  logic          i_ret,
  input  logic [AW-1:0] i_incPC,
  input  logic [25:0]   i_imm26,
  input  logic [AW-1:0] i_reg_target,
  output logic [AW-1:0] o_pc,
  output logic          o_valid,
  output logic          o_flush,
  output logic [CW-1:0] o_taken_cnt,
  output logic          o_ras_hit
);
  typedef enum logic [1:0] {BOOT, RUN, HALT} state_t;
  state_t state, state_nx;
  logic taken, redirect, ras_use, pend, pend_nx, flush_nx;
  logic [AW-1:0] ras_top, target, pc_nx, pend_tgt, pend_tgt_nx;
`ifdef PC_SEQ_RAS_EN
  localparam int SW = $clog2(RAS_DEPTH);
  localparam logic [SW:0] FULL = (SW+1)'(RAS_DEPTH);
  logic [AW-1:0] ras [RAS_DEPTH];
  logic [SW-1:0] sp;
  logic [SW:0] depth;
  logic push;
  assign push = i_br_valid & i_call;
  assign ras_use = i_br_valid & i_jr & i_ret & (depth != '0);
  assign ras_top = ras[sp - 1'b1];
  // Circular pointer: a push onto a full stack silently overwrites the oldest entry.
  always_ff @(posedge i_clk or negedge i_rst_n)
    if (!i_rst_n) begin
      sp <= '0;
      depth <= '0;
      o_ras_hit <= 1'b0;
    end else begin
      if (i_br_valid & i_jr) o_ras_hit <= ras_use;
      if (push & !ras_use) begin
        sp <= sp + 1'b1;
        depth <= (depth == FULL) ? depth : depth + 1'b1;
      end else if (!push & ras_use) begin
        sp <= sp - 1'b1;
        depth <= depth - 1'b1;
      end
    end
  always_ff @(posedge i_clk)
    if (push) ras[ras_use ? sp - 1'b1 : sp] <= i_incPC;
`else
  logic unused_ras;
  assign unused_ras = i_call ^ i_ret;
  assign ras_use = 1'b0;
  assign ras_top = '0;
  assign o_ras_hit = 1'b0;
`endif
  always_comb begin
    taken = 1'b0;
    case (i_cond)
      3'b001: taken = i_zero;
      3'b010: taken = ~i_zero;
      3'b011: taken = i_zero | i_neg;
      3'b100: taken = ~i_zero & ~i_neg;
      3'b101: taken = i_neg;
      3'b110: taken = ~i_neg;
      default: taken = 1'b0;
    endcase
  end
  assign redirect = i_br_valid & (i_jr | i_jump | taken);
  assign target = i_jr ? (ras_use ? ras_top : i_reg_target)
                : i_jump ? {i_incPC[AW-1:26], i_imm26}
                : i_incPC + {{(AW-16){i_imm26[15]}}, i_imm26[15:0]};
  // Outside RUN redirects are parked and replayed on the transition into RUN.
  always_comb begin
    state_nx = state;
    pc_nx = o_pc;
    flush_nx = 1'b0;
    pend_nx = pend;
    pend_tgt_nx = pend_tgt;
    if (state == RUN) begin
      pc_nx = redirect ? target : i_stall ? o_pc : o_pc + 1'b1;
      flush_nx = redirect;
      state_nx = i_halt ? HALT : RUN;
    end else begin
      pend_nx = pend | redirect;
      pend_tgt_nx = redirect ? target : pend_tgt;
      if (state == BOOT || (i_resume && !i_halt)) begin
        state_nx = RUN;
        pc_nx = pend_nx ? pend_tgt_nx : o_pc;
        flush_nx = pend_nx;
        pend_nx = 1'b0;
      end
    end
  end
  always_ff @(posedge i_clk or negedge i_rst_n)
    if (!i_rst_n) begin
      state <= BOOT;
      o_pc <= RESET_ADDR;
      o_valid <= 1'b0;
      o_flush <= 1'b0;
      o_taken_cnt <= '0;
      pend <= 1'b0;
      pend_tgt <= '0;
    end else begin
      state <= state_nx;
      o_pc <= pc_nx;
      o_valid <= (state_nx == RUN);
      o_flush <= flush_nx;
      pend <= pend_nx;
      pend_tgt <= pend_tgt_nx;
      if (redirect && o_taken_cnt != '1) o_taken_cnt <= o_taken_cnt + 1'b1;
    end
endmodule

// File: tb/tb_pc_sequencer.sv
// tb_pc_sequencer: table-driven, directed and randomized checks of pc_sequencer against a queue-based model.
module tb_pc_sequencer;
`ifdef PC_SEQ_RAS_EN
  localparam bit RAS_EN = 1'b1;
`else
  localparam bit RAS_EN = 1'b0;
`endif
  localparam int DEPTH = 2;
  localparam logic [31:0] MASK = 32'h3FFF_FFFF;

  logic i_clk = 1'b0, i_rst_n = 1'b1;
  logic i_stall, i_halt, i_resume, i_br_valid, i_zero, i_neg, i_jump, i_jr, i_call, i_ret;
  logic [2:0] i_cond;
  logic [29:0] i_incPC, i_reg_target;
  logic [25:0] i_imm26;
  logic [29:0] o_pc, s_pc;
  logic o_valid, o_flush, o_ras_hit, s_valid, s_flush, s_ras_hit;
  logic [15:0] o_taken_cnt;
  logic [1:0] s_taken_cnt;

  pc_sequencer #(.AW(30), .RESET_ADDR(30'h100), .CW(16), .RAS_DEPTH(DEPTH)) dut (
    .i_clk(i_clk), .i_rst_n(i_rst_n), .i_stall(i_stall), .i_halt(i_halt), .i_resume(i_resume),
    .i_br_valid(i_br_valid), .i_cond(i_cond), .i_zero(i_zero), .i_neg(i_neg), .i_jump(i_jump),
    .i_jr(i_jr), .i_call(i_call), .i_ret(i_ret), .i_incPC(i_incPC), .i_imm26(i_imm26),
    .i_reg_target(i_reg_target), .o_pc(o_pc), .o_valid(o_valid), .o_flush(o_flush),
    .o_taken_cnt(o_taken_cnt), .o_ras_hit(o_ras_hit));

  pc_sequencer #(.AW(30), .RESET_ADDR(30'h100), .CW(2), .RAS_DEPTH(DEPTH)) dut_sat (
    .i_clk(i_clk), .i_rst_n(i_rst_n), .i_stall(i_stall), .i_halt(i_halt), .i_resume(i_resume),
    .i_br_valid(i_br_valid), .i_cond(i_cond), .i_zero(i_zero), .i_neg(i_neg), .i_jump(i_jump),
    .i_jr(i_jr), .i_call(i_call), .i_ret(i_ret), .i_incPC(i_incPC), .i_imm26(i_imm26),
    .i_reg_target(i_reg_target), .o_pc(s_pc), .o_valid(s_valid), .o_flush(s_flush),
    .o_taken_cnt(s_taken_cnt), .o_ras_hit(s_ras_hit));

  always #5 i_clk = ~i_clk;

  int vectors = 0, errors = 0;
  int m_mode;
  logic [31:0] m_pc, m_ptgt;
  bit m_pend, m_valid, m_flush, m_hit;
  int m_cnt, m_cnt2;
  logic [31:0] m_ras[$];

  typedef struct {
    logic [2:0] cond; bit z; bit n; logic [29:0] inc; logic [15:0] imm; bit tk; logic [31:0] tgt;
  } vec_t;
  vec_t tbl [14];

  task automatic chk(string n, logic [31:0] act, logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h at %0t", n, act, exp, $time);
    end
  endtask

  task automatic check_all();
    chk("pc", 32'(o_pc), m_pc);
    chk("valid", 32'(o_valid), 32'(m_valid));
    chk("flush", 32'(o_flush), 32'(m_flush));
    chk("taken_cnt", 32'(o_taken_cnt), 32'(m_cnt));
    chk("taken_cnt_cw2", 32'(s_taken_cnt), 32'(m_cnt2));
    chk("ras_hit", 32'(o_ras_hit), 32'(m_hit));
  endtask

  task automatic model_reset();
    m_mode = 0; m_pc = 32'h100; m_pend = 0; m_ptgt = 0; m_valid = 0; m_flush = 0; m_hit = 0;
    m_cnt = 0; m_cnt2 = 0; m_ras.delete();
  endtask

  function automatic bit cond_taken(logic [2:0] c, bit z, bit n);
    case (c)
      3'd1: return z;
      3'd2: return !z;
      3'd3: return z || n;
      3'd4: return !z && !n;
      3'd5: return n;
      3'd6: return !n;
      default: return 1'b0;
    endcase
  endfunction

  // Mode 0 = boot, 1 = run, 2 = halt; RAS is a bounded queue whose back is the top.
  task automatic model_step();
    bit redir, from_ras;
    logic [31:0] tgt, inc;
    inc = 32'(i_incPC);
    redir = i_br_valid && (i_jr || i_jump || cond_taken(i_cond, i_zero, i_neg));
    from_ras = RAS_EN && i_br_valid && i_jr && i_ret && m_ras.size() > 0;
    if (i_jr) tgt = from_ras ? m_ras[$] : 32'(i_reg_target);
    else if (i_jump) tgt = (inc & 32'h3C00_0000) | 32'(i_imm26);
    else tgt = (inc + {{16{i_imm26[15]}}, i_imm26[15:0]}) & MASK;
    if (RAS_EN && i_br_valid) begin
      if (i_jr) m_hit = from_ras;
      if (from_ras) void'(m_ras.pop_back());
      if (i_call) begin
        m_ras.push_back(inc);
        if (m_ras.size() > DEPTH) void'(m_ras.pop_front());
      end
    end
    if (redir) begin
      if (m_cnt < 65535) m_cnt++;
      if (m_cnt2 < 3) m_cnt2++;
    end
    m_flush = 0;
    if (m_mode == 1) begin
      if (redir) begin m_pc = tgt; m_flush = 1; end
      else if (!i_stall) m_pc = (m_pc + 1) & MASK;
      if (i_halt) m_mode = 2;
    end else begin
      if (redir) begin m_pend = 1; m_ptgt = tgt; end
      if (m_mode == 0 || (i_resume && !i_halt)) begin
        m_mode = 1;
        if (m_pend) begin m_pc = m_ptgt; m_flush = 1; m_pend = 0; end
      end
    end
    m_valid = (m_mode == 1);
  endtask

  task automatic step();
    model_step();
    @(posedge i_clk);
    #1;
    check_all();
  endtask

  task automatic idle();
    i_stall = 0; i_halt = 0; i_resume = 0; i_br_valid = 0; i_cond = 0; i_zero = 0; i_neg = 0;
    i_jump = 0; i_jr = 0; i_call = 0; i_ret = 0; i_incPC = 0; i_imm26 = 0; i_reg_target = 0;
  endtask

  task automatic do_reset();
    i_rst_n = 1'b0;
    #2;
    model_reset();
    check_all();
    @(negedge i_clk);
    i_rst_n = 1'b1;
  endtask

  logic [31:0] frozen, prev, exp_pc;
  logic [31:0] ras_pc [3];
  bit ras_ht [3];

  initial begin
    tbl[0]  = '{3'd1, 1, 0, 30'h200, 16'hFFFE, 1, 32'h1FE};
    tbl[1]  = '{3'd1, 0, 0, 30'h200, 16'hFFFE, 0, 32'h0};
    tbl[2]  = '{3'd2, 0, 0, 30'h300, 16'h0004, 1, 32'h304};
    tbl[3]  = '{3'd2, 1, 0, 30'h300, 16'h0004, 0, 32'h0};
    tbl[4]  = '{3'd3, 0, 1, 30'h400, 16'h0010, 1, 32'h410};
    tbl[5]  = '{3'd3, 0, 0, 30'h400, 16'h0010, 0, 32'h0};
    tbl[6]  = '{3'd4, 0, 0, 30'h040, 16'h0010, 1, 32'h50};
    tbl[7]  = '{3'd4, 1, 0, 30'h040, 16'h0010, 0, 32'h0};
    tbl[8]  = '{3'd5, 0, 1, 30'h010, 16'hFFF0, 1, 32'h0};
    tbl[9]  = '{3'd5, 0, 0, 30'h010, 16'hFFF0, 0, 32'h0};
    tbl[10] = '{3'd6, 0, 0, 30'h005, 16'hFFFA, 1, 32'h3FFF_FFFF};
    tbl[11] = '{3'd6, 0, 1, 30'h005, 16'hFFFA, 0, 32'h0};
    tbl[12] = '{3'd0, 1, 1, 30'h100, 16'h0001, 0, 32'h0};
    tbl[13] = '{3'd7, 1, 1, 30'h100, 16'h0001, 0, 32'h0};
    if (RAS_EN) begin
      ras_pc = '{32'h30, 32'h20, 32'h999}; ras_ht = '{1, 1, 0};
    end else begin
      ras_pc = '{32'h999, 32'h999, 32'h999}; ras_ht = '{0, 0, 0};
    end
    idle();
    #1;
    do_reset();
    chk("reset_valid", 32'(o_valid), 0);
    chk("reset_pc", 32'(o_pc), 32'h100);
    step(); chk("boot_pc", 32'(o_pc), 32'h100); chk("boot_valid", 32'(o_valid), 1);
    step(); chk("run_pc1", 32'(o_pc), 32'h101);
    step(); chk("run_pc2", 32'(o_pc), 32'h102);

    for (int i = 0; i < 14; i++) begin
      i_br_valid = 1; i_cond = tbl[i].cond; i_zero = tbl[i].z; i_neg = tbl[i].n;
      i_incPC = tbl[i].inc; i_imm26 = {10'h0, tbl[i].imm};
      prev = m_pc;
      step();
      exp_pc = tbl[i].tk ? tbl[i].tgt : (prev + 1) & MASK;
      chk($sformatf("tbl%0d_pc", i), 32'(o_pc), exp_pc);
      chk($sformatf("tbl%0d_flush", i), 32'(o_flush), 32'(tbl[i].tk));
      if (i == 0) chk("first_cnt", 32'(o_taken_cnt), 1);
      idle();
      step();
    end

    i_stall = 1; i_br_valid = 1; i_cond = 3'd4; i_incPC = 30'h40; i_imm26 = 26'h10;
    step(); chk("stall_redirect_pc", 32'(o_pc), 32'h50);
    i_br_valid = 0;
    for (int i = 0; i < 3; i++) begin
      step(); chk("stall_hold_pc", 32'(o_pc), 32'h50);
    end
    idle();

    i_halt = 1; step(); i_halt = 0;
    frozen = m_pc;
    i_br_valid = 1; i_jump = 1; i_incPC = 30'h3C00_0010; i_imm26 = 26'h0000ABC;
    step(); chk("halt_frozen_pc", 32'(o_pc), frozen); chk("halt_valid", 32'(o_valid), 0);
    idle();
    step(); chk("halt_frozen_pc2", 32'(o_pc), frozen);
    i_resume = 1;
    step(); chk("resume_pc", 32'(o_pc), 32'h3C00_0ABC); chk("resume_flush", 32'(o_flush), 1);
    i_resume = 0;
    step(); chk("resume_flush_end", 32'(o_flush), 0);

    i_br_valid = 1; i_jr = 1; i_reg_target = 30'h3FFF_FFFF;
    step(); chk("wrap_top", 32'(o_pc), 32'h3FFF_FFFF);
    idle();
    step(); chk("wrap_zero", 32'(o_pc), 32'h0);

    for (int i = 0; i < 5; i++) begin
      i_br_valid = 1; i_jump = 1; i_incPC = 30'(i); i_imm26 = 26'(i * 16);
      step();
    end
    chk("cw2_saturated", 32'(s_taken_cnt), 3);
    i_br_valid = 1; i_jr = 1; i_jump = 1; i_cond = 3'd1; i_zero = 1;
    i_incPC = 30'h200; i_imm26 = 26'hABC; i_reg_target = 30'h777;
    step(); chk("priority_jr", 32'(o_pc), 32'h777);
    idle();

    for (int i = 1; i <= 3; i++) begin
      i_br_valid = 1; i_jump = 1; i_call = 1; i_incPC = 30'(i * 16); i_imm26 = 26'h1000;
      step();
    end
    for (int i = 0; i < 3; i++) begin
      idle(); i_br_valid = 1; i_jr = 1; i_ret = 1; i_reg_target = 30'h999;
      step();
      chk($sformatf("ras_pc%0d", i), 32'(o_pc), ras_pc[i]);
      chk($sformatf("ras_hit%0d", i), 32'(o_ras_hit), 32'(ras_ht[i]));
    end
    idle();

    for (int i = 0; i < 400; i++) begin
      i_stall = ($urandom_range(0, 3) == 0);
      i_halt = ($urandom_range(0, 15) == 0);
      i_resume = ($urandom_range(0, 3) == 0);
      i_br_valid = ($urandom_range(0, 2) != 0);
      i_cond = 3'($urandom());
      i_zero = 1'($urandom());
      i_neg = 1'($urandom());
      i_jump = ($urandom_range(0, 5) == 0);
      i_jr = ($urandom_range(0, 5) == 0);
      i_call = ($urandom_range(0, 3) == 0);
      i_ret = ($urandom_range(0, 2) == 0);
      i_incPC = 30'($urandom());
      i_imm26 = 26'($urandom());
      i_reg_target = 30'($urandom());
      if (i == 200) begin
        idle();
        do_reset();
      end else begin
        step();
      end
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
    $finish;
  end
endmodule
